// File: rtl/uart_pkg.sv
//==============================================================================
// Module : uart_pkg
// Brief  : State encoding and default bit timing shared by the UART RX and TX.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    // 9600 baud from a 100 MHz clock
    localparam int c_DEFAULT_CLKS_PER_BIT = 10417;
    localparam int c_CNT_W                = 15;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
//==============================================================================
// Module : uart_rx_sync
// Brief  : Two-flop synchronizer for the serial line; resets to the idle level.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
        end
    end

    assign dout = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_recv.sv
//==============================================================================
// Module : uart_recv
// Brief  : 8N1 UART receiver, mid-bit sampling, one-cycle valid/frame_err.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module uart_recv
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic               w_rx_s;
    logic               r_rx_prev;
    uart_state_t        r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_ferr;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_prev <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_prev <= w_rx_s;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    // Only a true falling edge starts a frame; a line that stays low does not
                    if (r_rx_prev && !w_rx_s) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_shift[r_idx] <= w_rx_s;
                        r_cnt          <= '0;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a start bit with no idle gap is still seen
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_recv.sv
//==============================================================================
// Module : tb_uart_recv
// Brief  : Directed, table-driven bench for uart_recv at 16 clocks per bit.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_uart_recv;

    localparam int c_BIT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_both = 0;

    typedef struct {
        logic [7:0] byte_v;
        logic       stop;
        int         gap;
        int         exp_v;
        int         exp_f;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    uart_recv #(.CLKS_PER_BIT(c_BIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (frame_err) n_ferr++;
        if (valid && frame_err) n_both++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        din = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_hold(input logic v);
        din = v;
        repeat (c_BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bit_hold(1'b0);
        for (int i = 0; i < 8; i++) bit_hold(b[i]);
        bit_hold(stop);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] b, input logic stop,
                               input int ev, input int ef, input logic [7:0] ed);
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(b, stop);
        check({tag, "_valid_cnt"}, n_valid - v0, ev);
        check({tag, "_ferr_cnt"}, n_ferr - f0, ef);
        check({tag, "_data"}, int'(data), int'(ed));
    endtask

    initial begin
        int v0, f0, b;

        vecs[0] = '{8'h55, 1'b1, 20, 1, 0, 8'h55};
        vecs[1] = '{8'hA3, 1'b1,  0, 1, 0, 8'hA3};
        vecs[2] = '{8'h0F, 1'b1, 20, 1, 0, 8'h0F};
        vecs[3] = '{8'h3C, 1'b1, 20, 1, 0, 8'h3C};
        vecs[4] = '{8'h81, 1'b0, 20, 0, 1, 8'h3C};
        vecs[5] = '{8'h00, 1'b1, 20, 1, 0, 8'h00};
        vecs[6] = '{8'hFF, 1'b1, 20, 1, 0, 8'hFF};

        rst = 1'b1;
        din = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_ferr", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        idle(20);

        for (int i = 0; i < 7; i++) begin
            frame_check($sformatf("vec%0d", i), vecs[i].byte_v, vecs[i].stop,
                        vecs[i].exp_v, vecs[i].exp_f, vecs[i].exp_data);
            if (vecs[i].gap > 0) begin
                idle(vecs[i].gap);
                check($sformatf("vec%0d_busy_after", i), int'(busy), 0);
            end
        end

        // Short low glitch on the line must be rejected during the start bit
        v0 = n_valid;
        f0 = n_ferr;
        b = 0;
        din = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) din = 1'b1;
            @(posedge clk);
            #1;
            if (busy) b++;
        end
        check("glitch_busy_seen", int'(b > 0), 1);
        check("glitch_busy_max12", int'(b <= 12), 1);
        check("glitch_valid", n_valid - v0, 0);
        check("glitch_ferr", n_ferr - f0, 0);
        check("glitch_busy_end", int'(busy), 0);

        // Break: exactly one frame error, then stay idle while the line is low
        v0 = n_valid;
        f0 = n_ferr;
        b = 0;
        din = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (i >= 250 && busy) b++;
        end
        check("break_ferr", n_ferr - f0, 1);
        check("break_valid", n_valid - v0, 0);
        check("break_busy_late", b, 0);
        idle(20);
        check("break_busy_after_rise", int'(busy), 0);
        check("break_ferr_after_rise", n_ferr - f0, 1);
        frame_check("after_break", 8'h5A, 1'b1, 1, 0, 8'h5A);
        idle(20);

        // Reset partway through bit 3 of a frame
        v0 = n_valid;
        f0 = n_ferr;
        bit_hold(1'b0);
        bit_hold(1'b1);
        bit_hold(1'b1);
        bit_hold(1'b1);
        din = 1'b0;
        repeat (c_BIT / 2) @(posedge clk);
        #1;
        check("midrst_busy_before", int'(busy), 1);
        din = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_data", int'(data), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_ferr", int'(frame_err), 0);
        check("midrst_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(40);
        check("midrst_no_valid", n_valid - v0, 0);
        check("midrst_no_ferr", n_ferr - f0, 0);
        frame_check("after_rst", 8'hC6, 1'b1, 1, 0, 8'hC6);
        idle(20);

        check("valid_ferr_overlap", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
